// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV64M multiply/divide unit: funct3 opcodes and FSM states.
// The decode/control stage imports the same opcode constants.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    // Operand A is treated as signed for MULH, MULHSU, DIV and REM.
    function automatic logic op_signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Operand B is treated as signed for MULH, DIV and REM.
    function automatic logic op_signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Final-cycle result formation: sign correction of the magnitude result and the
// divide-by-zero / signed-overflow overrides.
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] a_mag,
    input  logic            neg_a,
    input  logic            neg_b,
    input  logic            div_zero,
    input  logic            ovf,
    output logic [XLEN-1:0] result
);

    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   dividend;
    logic              neg_res;

    always_comb begin
        neg_res  = neg_a ^ neg_b;
        prod     = {acc, lo};
        prod_fix = neg_res ? -prod : prod;
        quot_fix = neg_res ? -lo : lo;
        // Remainder follows the dividend's sign; dividend is rebuilt from its magnitude.
        rem_fix  = neg_a ? -acc : acc;
        dividend = neg_a ? -a_mag : a_mag;

        result = '0;
        case (op)
            OP_MUL: result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU: begin
                if (div_zero)
                    result = '1;
                else if (ovf)
                    result = {1'b1, {(XLEN-1){1'b0}}};
                else
                    result = quot_fix;
            end
            default: begin
                if (div_zero)
                    result = dividend;
                else if (ovf)
                    result = '0;
                else
                    result = rem_fix;
            end
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV64M multiply/divide unit with fixed XLEN+2 edge latency.
// {acc, lo} is the product register for multiply and the remainder/quotient pair for divide.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int CW = $clog2(XLEN) + 1;

    state_e          state;
    state_e          state_nxt;
    logic [CW-1:0]   count;
    logic [2:0]      op_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] lo;
    logic            neg_a;
    logic            neg_b;
    logic            div_zero;
    logic            ovf;

    logic            in_neg_a;
    logic            in_neg_b;
    logic [XLEN-1:0] in_a_mag;
    logic [XLEN-1:0] in_b_mag;
    logic            in_ovf;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic [XLEN-1:0] fix_result;

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CALC;
            S_CALC:  if (count == CW'(XLEN - 1)) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    always_comb begin
        in_neg_a = op_signed_a(op) & rs1_data[XLEN-1];
        in_neg_b = op_signed_b(op) & rs2_data[XLEN-1];
        in_a_mag = in_neg_a ? -rs1_data : rs1_data;
        in_b_mag = in_neg_b ? -rs2_data : rs2_data;
        in_ovf   = ((op == OP_DIV) || (op == OP_REM)) &&
                   (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    end

    // One shift-add (multiply) or restoring-subtract (divide) step.
    always_comb begin
        mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, a_mag} : {(XLEN+1){1'b0}});
        div_shift = {acc, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_mag};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done     <= 1'b0;
            result   <= '0;
            rd_out   <= '0;
            count    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            a_mag    <= '0;
            b_mag    <= '0;
            acc      <= '0;
            lo       <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        rd_q     <= rd_in;
                        a_mag    <= in_a_mag;
                        b_mag    <= in_b_mag;
                        neg_a    <= in_neg_a;
                        neg_b    <= in_neg_b;
                        div_zero <= (rs2_data == '0);
                        ovf      <= in_ovf;
                        acc      <= '0;
                        lo       <= op[2] ? in_a_mag : in_b_mag;
                        count    <= '0;
                    end
                end
                S_CALC: begin
                    count <= count + CW'(1);
                    if (op_q[2]) begin
                        if (!div_diff[XLEN]) begin
                            acc <= div_diff[XLEN-1:0];
                            lo  <= {lo[XLEN-2:0], 1'b1};
                        end else begin
                            acc <= div_shift[XLEN-1:0];
                            lo  <= {lo[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        acc <= mul_sum[XLEN:1];
                        lo  <= {mul_sum[0], lo[XLEN-1:1]};
                    end
                end
                S_FIX: begin
                    result <= fix_result;
                    rd_out <= rd_q;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    muldiv_signfix #(.XLEN(XLEN)) u_signfix (
        .op       (op_q),
        .acc      (acc),
        .lo       (lo),
        .a_mag    (a_mag),
        .neg_a    (neg_a),
        .neg_b    (neg_b),
        .div_zero (div_zero),
        .ovf      (ovf),
        .result   (fix_result)
    );

endmodule
